mul_iter_acc: RTL and testbench
===============================

# mul_iter_acc

Parametrised iterative multiply/multiply-accumulate unit for the EX stage. It executes MULT/MULTU and MADD/MADDU/MSUB/MSUBU over several cycles, retiring BITS_PER_CYCLE multiplier bits per iteration. It takes a start pulse and an accumulator input (the current HI/LO), and returns a registered 2*WIDTH result with a one-cycle ready pulse. The pipeline stalls while busy_o is high.

## Interface
- WIDTH, 32, operand width; even, at least 4.
- BITS_PER_CYCLE, 2, multiplier bits retired per iteration; one of 1, 2, 4; must divide WIDTH.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  request; sampled only in IDLE.
- annul_i  in  1  cancel current operation (flush/exception).
- signed_i  in  1  1 = two's-complement operands, 0 = unsigned.
- mode_i  in  2  00 = MUL, 01 = MADD, 10 = MSUB, 11 = treated as MUL.
- op1_i  in  WIDTH  multiplicand.
- op2_i  in  WIDTH  multiplier.
- acc_i  in  2*WIDTH  accumulator ({HI,LO}); used only for MADD/MSUB.
- busy_o  out  1  operation in flight.
- ready_o  out  1  one-cycle pulse when result_o is updated.
- result_o  out  2*WIDTH  final result; held until the next completion.

## Operation
- States: IDLE, CALC, FIX.
- **IDLE**
  - An accepted start is start_i=1 with annul_i=0.
  - On an accepted start, latch the following:
    - signed_i and mode_i.
    - acc_i.
    - The magnitudes of op1/op2: two's-complement negate if signed_i=1 and the MSB is 1. The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), held as an unsigned WIDTH value.
    - neg = signed_i & (op1_i[MSB] ^ op2_i[MSB]).
  - Clear the product accumulator and the iteration counter.
  - If op1_i==0 or op2_i==0, go directly to FIX with product 0. Otherwise go to CALC.
- **CALC**, one iteration per cycle:
  - product += zero-extended (multiplicand * multiplier[BITS_PER_CYCLE-1:0]).
  - Shift the multiplicand left by BITS_PER_CYCLE.
  - Shift the multiplier right by BITS_PER_CYCLE.
  - Increment the counter.
  - After N = WIDTH/BITS_PER_CYCLE iterations, go to FIX.
- **FIX**, one cycle:
  - p = neg ? -product : product.
  - result_o <= MUL: p; MADD: acc + p; MSUB: acc - p. All arithmetic is modulo 2^(2*WIDTH).
  - ready_o <= 1, then go to IDLE.
- busy_o = 1 in CALC and FIX.
- ready_o = 1 for exactly the one cycle after FIX; otherwise 0.
- annul_i=1 in CALC or FIX:
  - Go to IDLE at the next edge.
  - No ready pulse; result_o is unchanged.
- annul_i=1 together with start_i in IDLE: the start is ignored.
- start_i in CALC/FIX is ignored; it is not queued.
- mode 11 behaves as MUL and acc is ignored.
- Operands are latched, so changes on op1_i/op2_i/acc_i/signed_i/mode_i after acceptance have no effect.

## Timing
- Reset:
  - state = IDLE.
  - busy_o = 0, ready_o = 0, result_o = 0.
  - Counter and internal registers cleared.
  - Applies from any state, including mid-CALC.
- Accepted start sampled at edge E0; busy_o is high from E0.
- Nonzero operands:
  - CALC occupies edges E1..EN; FIX executes at E(N+1).
  - ready_o and the new result_o are visible after E(N+1).
  - Latency is N+1 cycles: 17 for WIDTH=32/BPC=2, 33 for BPC=1, 9 for BPC=4.
- Zero operand: FIX executes at E1, so latency is 1 cycle.
- Back-to-back: a start may be accepted in the same cycle that ready_o is high, because the state is already IDLE.
- Throughput: one operation per N+2 cycles.

## Test plan
- **Unsigned max** (WIDTH=32, BPC=2), MUL.
  - Stimulus: op1=op2=0xFFFFFFFF.
  - Required: result 0xFFFFFFFE00000001; ready_o exactly 17 cycles after start, high for 1 cycle; busy_o high for 17 cycles.
- **Signed MUL.**
  - Stimulus: 0x80000000 * 0xFFFFFFFF; then 0xFFFFFFFD * 0x00000005.
  - Required: 0x0000000080000000; then 0xFFFFFFFFFFFFFFF1.
- **Accumulate.**
  - MADDU: acc=0xFFFFFFFFFFFFFFFF, 2*3 -> 0x0000000000000005 (wraps).
  - MSUB signed: acc=0, 2*3 -> 0xFFFFFFFFFFFFFFFA.
- **Zero early-out.**
  - Stimulus: MADD with op1=0, op2=0x1234, acc=0x10.
  - Required: result 0x10, ready 1 cycle after start.
- **Annul and ignored start.**
  - Annul on cycle 5 of CALC: no ready pulse; result_o keeps its previous value; busy_o low next cycle.
  - start_i pulsed mid-CALC: ignored, with exactly one completion.
  - New start immediately after annul: completes normally.
- **Reset mid-operation, and a parameter sweep.**
  - rst asserted during CALC: all outputs 0 next cycle.
  - Random signed/unsigned/mode vectors checked against a reference model for BPC=1,2,4 and WIDTH=8,16,32, with latencies N+1.

Source files
------------

// File: rtl/mul_iter_acc_if.sv
// Request/response bundle between the EX stage
// and the iterative multiply/accumulate unit.
interface mul_iter_acc_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               annul_i;
  logic               signed_i;
  logic [1:0]         mode_i;
  logic [WIDTH-1:0]   op1_i;
  logic [WIDTH-1:0]   op2_i;
  logic [2*WIDTH-1:0] acc_i;
  logic               busy_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;

  modport master (
    output start_i, annul_i, signed_i, mode_i,
    output op1_i, op2_i, acc_i,
    input  busy_o, ready_o, result_o
  );

  modport slave (
    input  start_i, annul_i, signed_i, mode_i,
    input  op1_i, op2_i, acc_i,
    output busy_o, ready_o, result_o
  );
endinterface

// File: rtl/mul_iter_acc.sv
// Iterative MULT/MADD/MSUB unit: magnitude shift-add,
// sign fix-up and accumulate in a final cycle.
module mul_iter_acc #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input logic           clk,
  input logic           rst,
  mul_iter_acc_if.slave bus
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int W2 = 2 * WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state;
  logic [W2-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic             neg;
  logic [1:0]       mode;
  logic             ready;
  logic [W2-1:0]    result;

  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [W2-1:0]    part;
  logic [W2-1:0]    p;
  logic [W2-1:0]    fix_val;
  logic             accept;
  logic             zero_op;
  logic             last;

  always_comb begin
    mag1 = bus.op1_i;
    mag2 = bus.op2_i;
    if (bus.signed_i && bus.op1_i[WIDTH-1])
      mag1 = -bus.op1_i;
    if (bus.signed_i && bus.op2_i[WIDTH-1])
      mag2 = -bus.op2_i;
    accept  = bus.start_i && !bus.annul_i;
    zero_op = (bus.op1_i == '0) ||
              (bus.op2_i == '0);
    part = mcand *
      W2'(mplier[BITS_PER_CYCLE-1:0]);
    last = (cnt == CW'(N - 1));
    p = neg ? -prod : prod;
    unique case (mode)
      2'b01:   fix_val = acc + p;
      2'b10:   fix_val = acc - p;
      default: fix_val = p;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      mode   <= 2'b00;
      ready  <= 1'b0;
      result <= '0;
    end else begin
      ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            mode   <= bus.mode_i;
            acc    <= bus.acc_i;
            mcand  <= W2'(mag1);
            mplier <= mag2;
            neg    <= bus.signed_i &
                      (bus.op1_i[WIDTH-1] ^
                       bus.op2_i[WIDTH-1]);
            prod   <= '0;
            cnt    <= '0;
            state  <= zero_op ? FIX : CALC;
          end
        end
        CALC: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else begin
            prod   <= prod + part;
            mcand  <= mcand << BITS_PER_CYCLE;
            mplier <= mplier >> BITS_PER_CYCLE;
            cnt    <= cnt + CW'(1);
            if (last)
              state <= FIX;
          end
        end
        FIX: begin
          if (!bus.annul_i) begin
            result <= fix_val;
            ready  <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o   = (state != IDLE);
  assign bus.ready_o  = ready;
  assign bus.result_o = result;
endmodule

// File: tb/tb_mul_iter_acc.sv
// Directed and randomised checks of mul_iter_acc
// across several WIDTH / BITS_PER_CYCLE settings.
module tb_mul_iter_acc;
  logic clk = 1'b0;
  logic rst;
  logic srst;
  int   errs = 0;
  int   checks = 0;
  int   done = 0;

  localparam int NC = 5;
  localparam int SW[NC] = '{8, 16, 32, 32, 8};
  localparam int SB[NC] = '{1, 4, 1, 4, 2};

  always #5 clk = ~clk;

  mul_iter_acc_if #(.WIDTH(32)) m();

  mul_iter_acc #(
    .WIDTH(32),
    .BITS_PER_CYCLE(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(m)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(
    input int w, input bit s,
    input logic [1:0] md,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [63:0] ac);
    logic [63:0] m1, m2, av, bv, p, r;
    m1 = (64'd1 << w) - 64'd1;
    m2 = (64'd1 << (2 * w)) - 64'd1;
    av = 64'(a) & m1;
    bv = 64'(b) & m1;
    if (s && a[w-1]) av = av | ~m1;
    if (s && b[w-1]) bv = bv | ~m1;
    p = av * bv;
    case (md)
      2'b01:   r = ac + p;
      2'b10:   r = ac - p;
      default: r = p;
    endcase
    return r & m2;
  endfunction

  // Caller must be at a negedge; returns at the
  // negedge where ready_o is first seen high.
  task automatic run(input bit s,
                     input logic [1:0] md,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [63:0] ac,
                     output int lat,
                     output int bsy);
    m.start_i  = 1'b1;
    m.signed_i = s;
    m.mode_i   = md;
    m.op1_i    = a;
    m.op2_i    = b;
    m.acc_i    = ac;
    @(negedge clk);
    m.start_i = 1'b0;
    lat = 0;
    bsy = 0;
    while (!m.ready_o && lat < 100) begin
      if (m.busy_o) bsy++;
      @(negedge clk);
      lat++;
    end
  endtask

  for (genvar g = 0; g < NC; g++) begin : sw
    localparam int W = SW[g];
    localparam int B = SB[g];
    localparam int N = W / B;
    mul_iter_acc_if #(.WIDTH(W)) sb();
    mul_iter_acc #(
      .WIDTH(W),
      .BITS_PER_CYCLE(B)
    ) u (
      .clk(clk),
      .rst(srst),
      .bus(sb)
    );
    initial begin
      logic [31:0] a, bb;
      logic [63:0] ac, exp;
      bit s;
      logic [1:0] md;
      int lat;
      int el;
      sb.start_i  = 1'b0;
      sb.annul_i  = 1'b0;
      sb.signed_i = 1'b0;
      sb.mode_i   = 2'b00;
      sb.op1_i    = '0;
      sb.op2_i    = '0;
      sb.acc_i    = '0;
      @(negedge clk);
      while (srst) @(negedge clk);
      for (int i = 0; i < 12; i++) begin
        a  = $urandom;
        bb = $urandom;
        ac = {$urandom, $urandom};
        s  = 1'($urandom);
        md = 2'($urandom);
        if (i == 0) a = 32'd0;
        if (i == 1) bb = 32'd0;
        if (i == 2) begin
          a  = 32'd1 << (W - 1);
          bb = 32'hFFFF_FFFF;
        end
        sb.start_i  = 1'b1;
        sb.signed_i = s;
        sb.mode_i   = md;
        sb.op1_i    = a[W-1:0];
        sb.op2_i    = bb[W-1:0];
        sb.acc_i    = ac[2*W-1:0];
        exp = model(W, s, md, a, bb, ac);
        el = (a[W-1:0] == '0 ||
              bb[W-1:0] == '0) ? 1 : N + 1;
        @(negedge clk);
        sb.start_i = 1'b0;
        lat = 0;
        while (!sb.ready_o && lat < 200) begin
          @(negedge clk);
          lat++;
        end
        chk($sformatf("sw%0d_res%0d", g, i),
            64'(sb.result_o), exp);
        chk($sformatf("sw%0d_lat%0d", g, i),
            64'(lat), 64'(el));
      end
      done++;
    end
  end

  initial begin
    int lat, bsy, pulses;
    logic [63:0] seen;
    logic [31:0] a, b;
    logic [63:0] ac;
    bit s;
    logic [1:0] md;
    rst = 1'b1;
    srst = 1'b1;
    m.start_i  = 1'b0;
    m.annul_i  = 1'b0;
    m.signed_i = 1'b0;
    m.mode_i   = 2'b00;
    m.op1_i    = '0;
    m.op2_i    = '0;
    m.acc_i    = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(m.busy_o), 64'd0);
    chk("rst_ready", 64'(m.ready_o), 64'd0);
    chk("rst_result", m.result_o, 64'd0);
    rst = 1'b0;
    srst = 1'b0;
    @(negedge clk);

    run(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        64'd0, lat, bsy);
    chk("umax_res", m.result_o,
        64'hFFFF_FFFE_0000_0001);
    chk("umax_lat", 64'(lat), 64'd17);
    chk("umax_busy", 64'(bsy), 64'd17);
    @(negedge clk);
    chk("umax_pulse", 64'(m.ready_o), 64'd0);
    chk("umax_idle", 64'(m.busy_o), 64'd0);

    run(1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF,
        64'd0, lat, bsy);
    chk("smul_min", m.result_o,
        64'h0000_0000_8000_0000);
    run(1, 2'b00, 32'hFFFF_FFFD, 32'h0000_0005,
        64'd0, lat, bsy);
    chk("smul_neg", m.result_o,
        64'hFFFF_FFFF_FFFF_FFF1);
    chk("b2b_lat", 64'(lat), 64'd17);

    run(0, 2'b01, 32'd2, 32'd3,
        64'hFFFF_FFFF_FFFF_FFFF, lat, bsy);
    chk("maddu_wrap", m.result_o, 64'd5);
    run(1, 2'b10, 32'd2, 32'd3, 64'd0, lat, bsy);
    chk("msub_s", m.result_o,
        64'hFFFF_FFFF_FFFF_FFFA);

    run(1, 2'b01, 32'd0, 32'h1234, 64'h10,
        lat, bsy);
    chk("zero_res", m.result_o, 64'h10);
    chk("zero_lat", 64'(lat), 64'd1);

    run(0, 2'b11, 32'd7, 32'd9, 64'h1234_5678,
        lat, bsy);
    chk("mode3_res", m.result_o, 64'd63);

    // annul after five CALC cycles
    @(negedge clk);
    m.start_i = 1'b1;
    m.mode_i  = 2'b00;
    m.op1_i   = 32'h1234;
    m.op2_i   = 32'h5678;
    @(negedge clk);
    m.start_i = 1'b0;
    repeat (5) @(negedge clk);
    m.annul_i = 1'b1;
    @(negedge clk);
    m.annul_i = 1'b0;
    chk("annul_busy", 64'(m.busy_o), 64'd0);
    chk("annul_ready", 64'(m.ready_o), 64'd0);
    chk("annul_hold", m.result_o, 64'd63);
    run(0, 2'b00, 32'h1_0000, 32'h1_0000,
        64'd0, lat, bsy);
    chk("post_annul_res", m.result_o,
        64'h1_0000_0000);
    chk("post_annul_lat", 64'(lat), 64'd17);

    // mid-CALC start and operand changes ignored
    @(negedge clk);
    m.start_i = 1'b1;
    m.signed_i = 1'b0;
    m.mode_i  = 2'b00;
    m.op1_i   = 32'd100;
    m.op2_i   = 32'd200;
    @(negedge clk);
    m.start_i = 1'b0;
    repeat (3) @(negedge clk);
    m.start_i = 1'b1;
    m.op1_i   = 32'd7;
    m.op2_i   = 32'd7;
    m.mode_i  = 2'b01;
    @(negedge clk);
    m.start_i = 1'b0;
    pulses = 0;
    seen = '0;
    for (int i = 0; i < 40; i++) begin
      if (m.ready_o) begin
        pulses++;
        seen = m.result_o;
      end
      @(negedge clk);
    end
    chk("ign_pulses", 64'(pulses), 64'd1);
    chk("ign_res", seen, 64'd20000);

    // synchronous reset during CALC
    m.start_i = 1'b1;
    m.mode_i  = 2'b00;
    m.op1_i   = 32'd3;
    m.op2_i   = 32'd5;
    @(negedge clk);
    m.start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", 64'(m.busy_o), 64'd0);
    chk("mrst_ready", 64'(m.ready_o), 64'd0);
    chk("mrst_result", m.result_o, 64'd0);
    run(0, 2'b00, 32'd3, 32'd5, 64'd0, lat, bsy);
    chk("mrst_recover", m.result_o, 64'd15);

    for (int i = 0; i < 8; i++) begin
      a  = $urandom;
      b  = $urandom;
      ac = {$urandom, $urandom};
      s  = 1'($urandom);
      md = 2'($urandom);
      run(s, md, a, b, ac, lat, bsy);
      chk($sformatf("rnd_res%0d", i), m.result_o,
          model(32, s, md, a, b, ac));
      chk($sformatf("rnd_lat%0d", i), 64'(lat),
          64'd17);
    end

    for (int t = 0; t < 5000 && done < NC; t++)
      @(negedge clk);
    chk("sweep_done", 64'(done), 64'(NC));

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end
endmodule
